// File: rtl/cen_gen_pkg.sv
// Shared encodings for the count-enable pattern generator: run modes and FSM states.
package cen_gen_pkg;

  localparam logic [1:0] MODE_ONE_SHOT = 2'd0;
  localparam logic [1:0] MODE_BURST    = 2'd1;
  localparam logic [1:0] MODE_CONT     = 2'd2;
  localparam logic [1:0] MODE_LEVEL    = 2'd3;

  localparam logic [2:0] ST_IDLE_ENC  = 3'd0;
  localparam logic [2:0] ST_DELAY_ENC = 3'd1;
  localparam logic [2:0] ST_ON_ENC    = 3'd2;
  localparam logic [2:0] ST_OFF_ENC   = 3'd3;
  localparam logic [2:0] ST_FIN_ENC   = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE  = ST_IDLE_ENC,
    ST_DELAY = ST_DELAY_ENC,
    ST_ON    = ST_ON_ENC,
    ST_OFF   = ST_OFF_ENC,
    ST_FIN   = ST_FIN_ENC
  } state_e;

endpackage

// File: rtl/cen_phase_cnt.sv
// Loadable down-counter shared by the DELAY, ON and OFF phases; flags expiry at zero.
module cen_phase_cnt #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  output logic             expired
);

  localparam logic [WIDTH-1:0] ONE = 1;

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == '0);

endmodule

// File: rtl/cen_pattern_gen.sv
// Run-time programmable count-enable generator: start delay, then ON/OFF phases.
// Outputs are registered from the current state, so they trail the FSM by one edge.
module cen_pattern_gen
  import cen_gen_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int MODE_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [MODE_W-1:0] mode,
  input  logic [WIDTH-1:0]  delay,
  input  logic [WIDTH-1:0]  on_len,
  input  logic [WIDTH-1:0]  off_len,
  input  logic [WIDTH-1:0]  bursts,
  output logic              cen,
  output logic              busy,
  output logic              done,
  output logic [WIDTH-1:0]  burst_idx
);

  localparam logic [WIDTH-1:0] ONE = 1;

  state_e            state_q, state_d;
  logic [MODE_W-1:0] mode_q, mode_d;
  logic [WIDTH-1:0]  on_len_q, on_len_d;
  logic [WIDTH-1:0]  off_len_q, off_len_d;
  logic [WIDTH-1:0]  bursts_q, bursts_d;
  logic [WIDTH-1:0]  idx_q, idx_d;
  logic              cen_q, cen_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [WIDTH-1:0]  burst_idx_q, burst_idx_d;

  logic             cnt_load;
  logic [WIDTH-1:0] cnt_load_val;
  logic             cnt_en;
  logic             cnt_expired;
  logic [WIDTH-1:0] last_idx;
  logic             is_level;

  cen_phase_cnt #(.WIDTH(WIDTH)) u_phase_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .en       (cnt_en),
    .expired  (cnt_expired)
  );

  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    on_len_d     = on_len_q;
    off_len_d    = off_len_q;
    bursts_d     = bursts_q;
    idx_d        = idx_q;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_en       = 1'b0;
    is_level     = (mode_q == MODE_W'(MODE_LEVEL));
    // bursts=0 behaves like a single burst
    last_idx     = (bursts_q == '0) ? '0 : (bursts_q - ONE);

    cen_d       = (state_q == ST_ON) && (is_level || (on_len_q != '0));
    busy_d      = (state_q == ST_DELAY) || (state_q == ST_ON) || (state_q == ST_OFF);
    done_d      = (state_q == ST_FIN);
    burst_idx_d = idx_q;

    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          mode_d    = mode;
          on_len_d  = on_len;
          off_len_d = off_len;
          bursts_d  = bursts;
          idx_d     = '0;
          cnt_load  = 1'b1;
          if (delay != '0) begin
            state_d      = ST_DELAY;
            cnt_load_val = delay - ONE;
          end else begin
            state_d      = ST_ON;
            cnt_load_val = on_len - ONE;
          end
        end
      end
      ST_DELAY: begin
        cnt_en = 1'b1;
        if (cnt_expired) begin
          state_d      = ST_ON;
          cnt_load     = 1'b1;
          cnt_load_val = on_len_q - ONE;
        end
      end
      ST_ON: begin
        // on_len=0 spends one silent cycle here so the sequence still terminates normally
        if (!is_level) begin
          cnt_en = 1'b1;
          if (cnt_expired || (on_len_q == '0)) begin
            if ((mode_q == MODE_W'(MODE_ONE_SHOT)) ||
                ((mode_q == MODE_W'(MODE_BURST)) && (idx_q >= last_idx))) begin
              state_d = ST_FIN;
            end else if (off_len_q == '0) begin
              idx_d        = idx_q + ONE;
              cnt_load     = 1'b1;
              cnt_load_val = on_len_q - ONE;
            end else begin
              state_d      = ST_OFF;
              cnt_load     = 1'b1;
              cnt_load_val = off_len_q - ONE;
            end
          end
        end
      end
      ST_OFF: begin
        cnt_en = 1'b1;
        if (cnt_expired) begin
          state_d      = ST_ON;
          idx_d        = idx_q + ONE;
          cnt_load     = 1'b1;
          cnt_load_val = on_len_q - ONE;
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (abort && (state_q != ST_IDLE)) begin
      state_d      = ST_IDLE;
      idx_d        = '0;
      cnt_load     = 1'b1;
      cnt_load_val = '0;
      cen_d        = 1'b0;
      busy_d       = 1'b0;
      done_d       = 1'b0;
      burst_idx_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      mode_q      <= '0;
      on_len_q    <= '0;
      off_len_q   <= '0;
      bursts_q    <= '0;
      idx_q       <= '0;
      cen_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      burst_idx_q <= '0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      on_len_q    <= on_len_d;
      off_len_q   <= off_len_d;
      bursts_q    <= bursts_d;
      idx_q       <= idx_d;
      cen_q       <= cen_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      burst_idx_q <= burst_idx_d;
    end
  end

  assign cen       = cen_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign burst_idx = burst_idx_q;

endmodule

// File: tb/tb_cen_pattern_gen.sv
// Directed bench for cen_pattern_gen: per-edge expectations queued, then checked after each edge.
module tb_cen_pattern_gen;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic [1:0]   mode = '0;
  logic [W-1:0] delay = '0;
  logic [W-1:0] on_len = '0;
  logic [W-1:0] off_len = '0;
  logic [W-1:0] bursts = '0;
  logic         cen;
  logic         busy;
  logic         done;
  logic [W-1:0] burst_idx;

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    logic         c;
    logic         b;
    logic         d;
    logic [W-1:0] idx;
  } obs_t;

  obs_t sb_q[$];

  cen_pattern_gen #(.WIDTH(W), .MODE_W(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .mode      (mode),
    .delay     (delay),
    .on_len    (on_len),
    .off_len   (off_len),
    .bursts    (bursts),
    .cen       (cen),
    .busy      (busy),
    .done      (done),
    .burst_idx (burst_idx)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic cyc(input string tag, input logic c, input logic b, input logic d,
                     input logic [W-1:0] idx);
    obs_t exp_v;
    obs_t got;
    sb_q.push_back({c, b, d, idx});
    @(posedge clk);
    #1;
    exp_v = sb_q.pop_front();
    got   = {cen, busy, done, burst_idx};
    n_vec++;
    assert (got === exp_v) else begin
      n_err++;
      $error("FAIL %s t=%0t got cen=%b busy=%b done=%b idx=%0d exp cen=%b busy=%b done=%b idx=%0d",
             tag, $time, got.c, got.b, got.d, got.idx, exp_v.c, exp_v.b, exp_v.d, exp_v.idx);
    end
  endtask

  task automatic chk_now(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
    n_vec++;
    assert (got === exp_v) else begin
      n_err++;
      $error("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp_v);
    end
  endtask

  task automatic cfg(input logic [1:0] m, input logic [W-1:0] dl, input logic [W-1:0] on,
                     input logic [W-1:0] off, input logic [W-1:0] nb);
    mode    = m;
    delay   = dl;
    on_len  = on;
    off_len = off;
    bursts  = nb;
    start   = 1'b1;
  endtask

  initial begin
    logic [13:0]  pat;
    logic [W-1:0] ei;
    int           ndone;

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_now("reset_state", 32'({cen, busy, done, burst_idx}), 32'd0);
    rst_n = 1'b1;
    for (int e = 0; e < 20; e++) cyc("idle", 1'b0, 1'b0, 1'b0, '0);
    $display("reset/idle scenario applied");

    // one-shot; config inputs are disturbed after capture and a second start arrives while busy
    cfg(2'd0, 8'd4, 8'd10, 8'd0, 8'd0);
    for (int e = 0; e <= 17; e++) begin
      cyc("oneshot", (e >= 5 && e <= 14), (e >= 1 && e <= 14), (e == 15), '0);
      start = (e == 6);
      if (e == 0) begin
        mode   = 2'd2;
        delay  = 8'd0;
        on_len = 8'd3;
      end
    end
    $display("one-shot scenario applied");

    pat = 14'b11000110001100;
    cfg(2'd1, 8'd0, 8'd2, 8'd3, 8'd3);
    for (int e = 0; e <= 15; e++) begin
      ei = (e <= 5) ? 8'd0 : ((e <= 10) ? 8'd1 : 8'd2);
      cyc("burst", (e >= 1 && e <= 14) ? pat[14-e] : 1'b0, (e >= 1 && e <= 12), (e == 13), ei);
      start = 1'b0;
    end
    $display("burst scenario applied");

    cfg(2'd1, 8'd0, 8'd2, 8'd0, 8'd3);
    for (int e = 0; e <= 9; e++) begin
      ei = (e == 0 || e > 6) ? 8'd2 : W'((e - 1) / 2);
      cyc("burst_off0", (e >= 1 && e <= 6), (e >= 1 && e <= 6), (e == 7), ei);
      start = 1'b0;
    end
    $display("burst off_len=0 scenario applied");

    cfg(2'd2, 8'd0, 8'd1, 8'd1, 8'd0);
    for (int e = 0; e <= 17; e++) begin
      ei = (e == 0) ? 8'd2 : W'((e - 1) / 2);
      cyc("cont", (e % 2 == 1), (e >= 1), 1'b0, ei);
      start = 1'b0;
    end
    abort = 1'b1;
    cyc("cont_abort", 1'b0, 1'b0, 1'b0, '0);
    abort = 1'b0;
    for (int e = 0; e < 3; e++) cyc("post_abort", 1'b0, 1'b0, 1'b0, '0);
    $display("continuous+abort scenario applied");

    cfg(2'd3, 8'd2, 8'd0, 8'd0, 8'd0);
    for (int e = 0; e <= 12; e++) begin
      cyc("level", (e >= 3), (e >= 1), 1'b0, '0);
      start = 1'b0;
    end
    abort = 1'b1;
    cyc("level_abort", 1'b0, 1'b0, 1'b0, '0);
    abort = 1'b0;
    $display("level scenario applied");

    cfg(2'd0, 8'd0, 8'd5, 8'd0, 8'd0);
    abort = 1'b1;
    cyc("start_abort", 1'b0, 1'b0, 1'b0, '0);
    start = 1'b0;
    abort = 1'b0;
    for (int e = 0; e < 4; e++) cyc("start_abort_idle", 1'b0, 1'b0, 1'b0, '0);
    $display("start+abort in idle scenario applied");

    cfg(2'd0, 8'd3, 8'd0, 8'd0, 8'd0);
    ndone = 0;
    for (int e = 0; e <= 10; e++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      chk_now("onlen0_cen", 32'(cen), 32'd0);
      if (done === 1'b1) ndone++;
    end
    chk_now("onlen0_done_count", 32'(ndone), 32'd1);
    chk_now("onlen0_busy_end", 32'(busy), 32'd0);
    $display("on_len=0 scenario applied");

    cfg(2'd0, 8'd0, 8'd10, 8'd0, 8'd0);
    cyc("areset_pre", 1'b0, 1'b0, 1'b0, '0);
    start = 1'b0;
    cyc("areset_on", 1'b1, 1'b1, 1'b0, '0);
    cyc("areset_on", 1'b1, 1'b1, 1'b0, '0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_now("areset_immediate", 32'({cen, busy, done}), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int e = 0; e < 15; e++) cyc("areset_after", 1'b0, 1'b0, 1'b0, '0);
    $display("async reset scenario applied");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
